fifo_pkt_consumer: RTL

- Read-side consumer that drains the dual-clock packet FIFO through its rpop/rempty/rdata interface, entirely in the rclk domain.
- Parses framed packets: header word, N payload words, XOR checksum word.
- Forwards payload words downstream on a valid/ready stream and reports per-packet status.
- Counterpart of the producer that pushes frames through wpush/wfull.

---
 rtl/fifo_pkt_pkg.sv | 20 ++
 rtl/fifo_pkt_out_reg.sv | 27 ++
 rtl/fifo_pkt_consumer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_pkt_pkg.sv
// Shared types and header field layout for the packet FIFO consumer.
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CSUM    = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam int HDR_MARK_MSB = 15;
  localparam int HDR_MARK_LSB = 12;
  localparam int HDR_CHAN_MSB = 11;
  localparam int HDR_CHAN_LSB = 8;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 0;

  localparam logic [3:0] HDR_MARK_DEF = 4'hA;

endpackage

// File: rtl/fifo_pkt_out_reg.sv
// Single-entry valid/ready output register; load takes effect next cycle.
// Holds data while out_ready is low; caller must not load into a stalled entry.
module fifo_pkt_out_reg #(
  parameter int DW = 16
) (
  input  logic          rclk,
  input  logic          rrstn,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_pkt_consumer.sv
// Drains framed packets (header, payload, XOR checksum) from the FIFO read port, one pop in flight.
// Word rate is 1 per 2 cycles; downstream stall blocks pops in PAYLOAD; pkt_done follows the last transfer.
module fifo_pkt_consumer
  import fifo_pkt_pkg::*;
#(
  parameter int         DW       = 16,
  parameter logic [3:0] HDR_MARK = HDR_MARK_DEF,
  parameter int         CNT_W    = 8
) (
  input  logic             rclk,
  input  logic             rrstn,
  output logic             rpop,
  input  logic             rempty,
  input  logic [DW-1:0]    rdata,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic [3:0]       pkt_chan,
  output logic [7:0]       pkt_len,
  output logic             pkt_err,
  output logic [15:0]      pkt_cnt,
  output logic [CNT_W-1:0] sync_err_cnt
);

  state_t        state, state_nxt;
  logic          pend;
  logic [DW-1:0] acc;
  logic [3:0]    chan_q;
  logic [7:0]    len_q;
  logic [7:0]    rem_q;
  logic          err_q;

  logic can_take;
  logic pop_acc;
  logic is_hdr;
  logic load;
  logic report_go;

  // A word may only be requested if there is guaranteed room to absorb it when it lands.
  assign can_take  = (state != REPORT) && ((state != PAYLOAD) || !out_valid || out_ready);
  assign rpop      = !rempty && !pend && can_take;
  assign pop_acc   = rpop && !rempty;
  assign is_hdr    = (rdata[HDR_MARK_MSB:HDR_MARK_LSB] == HDR_MARK);
  assign report_go = (state == REPORT) && !out_valid;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      HUNT: begin
        if (pend && is_hdr) begin
          state_nxt = (rdata[HDR_LEN_MSB:HDR_LEN_LSB] == 8'd0) ? CSUM : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pend) begin
          load = 1'b1;
          if (rem_q == 8'd1) state_nxt = CSUM;
        end
      end
      CSUM: begin
        if (pend) state_nxt = REPORT;
      end
      REPORT: begin
        if (!out_valid) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      state        <= HUNT;
      pend         <= 1'b0;
      acc          <= '0;
      chan_q       <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      sync_err_cnt <= '0;
      pkt_done     <= 1'b0;
      pkt_chan     <= '0;
      pkt_len      <= '0;
      pkt_err      <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pop_acc;

      if (pend) begin
        case (state)
          HUNT: begin
            if (is_hdr) begin
              chan_q <= rdata[HDR_CHAN_MSB:HDR_CHAN_LSB];
              len_q  <= rdata[HDR_LEN_MSB:HDR_LEN_LSB];
              rem_q  <= rdata[HDR_LEN_MSB:HDR_LEN_LSB];
              acc    <= rdata;
            end else if (sync_err_cnt != '1) begin
              sync_err_cnt <= sync_err_cnt + 1'b1;
            end
          end
          PAYLOAD: begin
            acc   <= acc ^ rdata;
            rem_q <= rem_q - 8'd1;
          end
          CSUM: begin
            err_q <= (rdata != acc);
          end
          default: ;
        endcase
      end

      // Status fields update together with the pulse so they are coherent while pkt_done is high.
      pkt_done <= report_go;
      if (report_go) begin
        pkt_chan <= chan_q;
        pkt_len  <= len_q;
        pkt_err  <= err_q;
        pkt_cnt  <= pkt_cnt + 16'd1;
      end
    end
  end

  fifo_pkt_out_reg #(.DW(DW)) u_out_reg (
    .rclk      (rclk),
    .rrstn     (rrstn),
    .load      (load),
    .load_data (rdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule
